cache_miss_controller: RTL and testbench
========================================

// Module: cache_miss_controller
// PURPOSE
//  Sequences the direct-mapped, write-back, write-allocate data cache in front of main memory.
//  Sits between the MEM pipeline stage and the cache/memory datapath, and drives its selects and enables.
//  Freezes the pipeline via stall while a miss is serviced over the multi-cycle memory.
//  Replaces the constant stall=0 tie-off in the core.
// PARAMETERS
//  MEM_LATENCY  4   main-memory access time in cycles, per read or write (legal >= 1)
//  CNT_W        32  width of performance counters (used only with CACHE_PERF_CNT_EN)
// PORTS
//  clk               in   1      rising-edge clock
//  rst_b             in   1      synchronous reset, ACTIVE-HIGH (1 = reset on next clk edge)
//  req_valid         in   1      MEM stage holds a load/store (lw/lb/sw/sb)
//  req_write         in   1      1 = store, 0 = load; valid with req_valid
//  hit               in   1      cache tag match for the current request address
//  dirty             in   1      dirty bit of the indexed (victim) line
//  stall             out  1      freeze PC and all pipeline registers
//  cache_we          out  1      write the cache data/tag/valid arrays this cycle
//  cache_fill_sel    out  1      cache data source: 0 = datapath store data, 1 = memory read data
//  dirty_wr          out  1      dirty value written along with cache_we (1 store, 0 fill)
//  mem_addr_sel      out  1      memory address: 0 = request address, 1 = victim tag/index address
//  mem_write_en      out  1      main-memory write enable
//  reg_write_enable  out  1      load data valid for writeback (load hit)
//  hit_count         out  CNT_W  (CACHE_PERF_CNT_EN only) accepted hits
//  miss_count        out  CNT_W  (CACHE_PERF_CNT_EN only) misses entered
// BEHAVIOUR
//  Moore FSM with states IDLE, WB, REFILL and FILL, plus a latency counter cnt of $clog2(MEM_LATENCY+1) bits.
//  Outputs are decoded from the state; in IDLE they also depend combinationally on req_valid, req_write and hit.
//  Reset: state=IDLE, cnt=0, counters=0.
//   - In reset, every output is 0 except as IDLE decodes its inputs.
//   - mem_write_en is 0 in IDLE.
//  IDLE:
//   - req_valid & hit & !req_write: reg_write_enable=1, stall=0. Zero-latency hit.
//   - req_valid & hit & req_write: cache_we=1, cache_fill_sel=0, dirty_wr=1, stall=0.
//   - req_valid & !hit: stall=1.
//     - dirty=1: go to WB.
//     - dirty=0: go to REFILL.
//     - In both cases cnt=0.
//   - !req_valid: all outputs 0, stay in IDLE.
//  WB:
//   - stall=1, mem_addr_sel=1, mem_write_en=1. Held constant for exactly MEM_LATENCY cycles.
//   - At cnt==MEM_LATENCY-1: go to REFILL, cnt=0. Otherwise cnt++.
//  REFILL:
//   - stall=1, mem_addr_sel=0, mem_write_en=0. Held for MEM_LATENCY cycles.
//   - At cnt==MEM_LATENCY-1: go to FILL.
//  FILL (1 cycle):
//   - stall=1, cache_we=1, cache_fill_sel=1, dirty_wr=0.
//   - Go to IDLE.
//  After FILL, IDLE re-evaluates the still-frozen request, which now hits. A store miss completes as a store hit there.
//  Stall cycles:
//   - Clean miss: MEM_LATENCY+2 cycles (detect cycle + REFILL + FILL).
//   - Dirty miss: 2*MEM_LATENCY+2 cycles.
//  hit, dirty and req_write are ignored outside IDLE. dirty is consumed only in the IDLE miss cycle.
//  req_valid deasserting mid-miss (flush): the transaction is not aborted.
//   - A writeback already started completes.
//   - The refill completes and the line is filled.
//   - FSM then returns to IDLE with no register writeback.
//  rst_b asserted in any state: IDLE on the next edge. An in-progress memory write is dropped; mem_write_en falls that edge.
//  Never in the same cycle: cache_we with mem_write_en; reg_write_enable with stall.
// CONFIGURATION
//  CACHE_PERF_CNT_EN defined:
//   - hit_count increments on each IDLE cycle with req_valid & hit & !stall.
//   - miss_count increments on each IDLE->WB or IDLE->REFILL transition.
//   - Both counters wrap modulo 2^CNT_W and clear on rst_b.
//  CACHE_PERF_CNT_EN undefined: counter ports and logic are absent; all other behaviour is identical.
// TESTING  (MEM_LATENCY=4)
//  1. Load, hit=1 -> same cycle reg_write_enable=1, stall=0; state stays IDLE.
//  2. Load, hit=0, dirty=0 -> stall=1 for 6 cycles.
//     - REFILL covers 4 cycles, with mem_write_en=0.
//     - FILL cycle: cache_we=1, cache_fill_sel=1.
//     - Then hit=1 -> reg_write_enable=1, stall=0.
//  3. Store, hit=0, dirty=1:
//     - mem_write_en=1 with mem_addr_sel=1 for exactly 4 cycles.
//     - Then 4 REFILL cycles and FILL.
//     - Then cache_we=1, cache_fill_sel=0, dirty_wr=1; stall total 10 cycles.
//  4. Dirty miss, deassert req_valid during the 2nd WB cycle -> WB+REFILL+FILL still complete; IDLE, no reg_write_enable.
//  5. rst_b=1 during the 3rd REFILL cycle:
//     - Next edge: IDLE, all outputs 0.
//     - Then a fresh miss restarts the full 6-cycle sequence.
//  6. CACHE_PERF_CNT_EN: 3 hits + 2 misses (one dirty) -> hit_count=3+2 (post-fill hits), miss_count=2.

Source files
------------

// File: rtl/cache_miss_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_miss_controller
// Brief    : Miss sequencer for a direct-mapped write-back write-allocate
//            data cache. Optional perf counters: define CACHE_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cache_miss_controller #(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic rst_b,
  input  logic req_valid,
  input  logic req_write,
  input  logic hit,
  input  logic dirty,
  output logic stall,
  output logic cache_we,
  output logic cache_fill_sel,
  output logic dirty_wr,
  output logic mem_addr_sel,
  output logic mem_write_en,
  output logic reg_write_enable
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
`endif
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] c_LAST = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_REFILL = 2'd2,
    S_FILL   = 2'd3
  } state_t;

  state_t          r_state, w_next_state;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;

  if (MEM_LATENCY < 1 || CNT_W < 1) begin : g_param_check
    $error("cache_miss_controller: MEM_LATENCY and CNT_W must be >= 1");
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_cnt_nxt        = r_cnt;
    stall            = 1'b0;
    cache_we         = 1'b0;
    cache_fill_sel   = 1'b0;
    dirty_wr         = 1'b0;
    mem_addr_sel     = 1'b0;
    mem_write_en     = 1'b0;
    reg_write_enable = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (hit) begin
            if (req_write) begin
              cache_we = 1'b1;
              dirty_wr = 1'b1;
            end else begin
              reg_write_enable = 1'b1;
            end
          end else begin
            stall        = 1'b1;
            w_cnt_nxt    = '0;
            w_next_state = dirty ? S_WB : S_REFILL;
          end
        end
      end
      S_WB: begin
        stall        = 1'b1;
        mem_addr_sel = 1'b1;
        mem_write_en = 1'b1;
        if (r_cnt == c_LAST) begin
          w_next_state = S_REFILL;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_REFILL: begin
        stall = 1'b1;
        if (r_cnt == c_LAST) begin
          w_next_state = S_FILL;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_FILL: begin
        stall          = 1'b1;
        cache_we       = 1'b1;
        cache_fill_sel = 1'b1;
        w_next_state   = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  // A miss is counted on the IDLE cycle that leaves IDLE, a hit on each accepted hit.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (r_state == S_IDLE && req_valid && hit && !stall)
        hit_count <= hit_count + CNT_W'(1);
      if (r_state == S_IDLE && w_next_state != S_IDLE)
        miss_count <= miss_count + CNT_W'(1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_miss_controller
// Brief    : Self-checking bench for cache_miss_controller (MEM_LATENCY=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_miss_controller;

  localparam int L = 4;

  // {stall, cache_we, fill_sel, dirty_wr, mem_addr_sel, mem_write_en, reg_we}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LDHIT = 7'b0000001;
  localparam logic [6:0] O_STHIT = 7'b0101000;
  localparam logic [6:0] O_MISS = 7'b1000000;
  localparam logic [6:0] O_WB = 7'b1000110;
  localparam logic [6:0] O_REF = 7'b1000000;
  localparam logic [6:0] O_FILL = 7'b1110000;

  logic clk = 1'b0;
  logic rst_b, req_valid, req_write, hit, dirty;
  logic stall, cache_we, cache_fill_sel, dirty_wr, mem_addr_sel, mem_write_en, reg_write_enable;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache_miss_controller #(.MEM_LATENCY(L), .CNT_W(32)) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_write(req_write),
    .hit(hit), .dirty(dirty), .stall(stall), .cache_we(cache_we),
    .cache_fill_sel(cache_fill_sel), .dirty_wr(dirty_wr),
    .mem_addr_sel(mem_addr_sel), .mem_write_en(mem_write_en),
    .reg_write_enable(reg_write_enable)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  typedef struct {
    logic [6:0] exp;
    string      name;
  } sb_t;

  typedef struct {
    logic       rv, rw, h, d;
    logic [6:0] exp;
    string      name;
  } vec_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      logic [6:0] act;
      e   = sb.pop_front();
      act = {stall, cache_we, cache_fill_sel, dirty_wr, mem_addr_sel, mem_write_en, reg_write_enable};
      n_cmp++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
      end
    end
  end

  task automatic drive(input logic r, input logic rv, input logic rw, input logic h,
                       input logic d, input logic [6:0] e, input string n);
    rst_b = r; req_valid = rv; req_write = rw; hit = h; dirty = d;
    sb.push_back('{exp: e, name: n});
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Inputs other than req_valid are randomised outside IDLE; they must be ignored.
  task automatic busy(input logic rv, input logic [6:0] e, input string n);
    drive(1'b0, rv, rbit(), rbit(), rbit(), e, n);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, O_NONE,  "idle_none"};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, O_NONE,  "idle_none_noise"};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, O_LDHIT, "load_hit"};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, O_LDHIT, "load_hit_dirty"};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, O_STHIT, "store_hit"};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, O_STHIT, "store_hit_dirty"};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, O_NONE,  "idle_noreq_miss"};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, O_LDHIT, "load_hit_again"};

    rst_b = 1'b1; req_valid = 1'b0; req_write = 1'b0; hit = 1'b0; dirty = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE,  "reset_state");
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_LDHIT, "reset_idle_decode");

    foreach (tbl[i]) drive(1'b0, tbl[i].rv, tbl[i].rw, tbl[i].h, tbl[i].d, tbl[i].exp, tbl[i].name);

    // Clean load miss: 6 stall cycles, then the frozen load hits.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_MISS, "clean_detect");
    for (int i = 0; i < L; i++) busy(1'b1, O_REF, "clean_refill");
    busy(1'b1, O_FILL, "clean_fill");
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_LDHIT, "clean_post_hit");

    // Dirty store miss: 4 WB, 4 REFILL, FILL, then completes as a store hit.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, O_MISS, "dirty_detect");
    for (int i = 0; i < L; i++) busy(1'b1, O_WB, "dirty_wb");
    for (int i = 0; i < L; i++) busy(1'b1, O_REF, "dirty_refill");
    busy(1'b1, O_FILL, "dirty_fill");
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, O_STHIT, "dirty_post_store");

    // Flush during the 2nd WB cycle: the miss still runs to completion.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, O_MISS, "flush_detect");
    busy(1'b1, O_WB, "flush_wb1");
    for (int i = 1; i < L; i++) busy(1'b0, O_WB, "flush_wb");
    for (int i = 0; i < L; i++) busy(1'b0, O_REF, "flush_refill");
    busy(1'b0, O_FILL, "flush_fill");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_NONE, "flush_idle");

    // Reset in the 3rd REFILL cycle, then a fresh full miss.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_MISS, "rst_detect");
    busy(1'b1, O_REF, "rst_refill1");
    busy(1'b1, O_REF, "rst_refill2");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_REF, "rst_refill3");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, "rst_after");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_MISS, "rst_redetect");
    for (int i = 0; i < L; i++) busy(1'b1, O_REF, "rst_rerefill");
    busy(1'b1, O_FILL, "rst_refill_fill");
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_LDHIT, "rst_post_hit");

    // Dirty miss with WB right after reset: mem_write_en must fall on the reset edge.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, O_MISS, "wbrst_detect");
    busy(1'b1, O_WB, "wbrst_wb1");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_WB, "wbrst_wb2");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, "wbrst_after");

`ifdef CACHE_PERF_CNT_EN
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, "perf_reset");
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'(i % 2), 1'b1, 1'b0, (i % 2) ? O_STHIT : O_LDHIT, "perf_hit");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_MISS, "perf_clean");
    for (int i = 0; i < L; i++) busy(1'b1, O_REF, "perf_clean_refill");
    busy(1'b1, O_FILL, "perf_clean_fill");
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_LDHIT, "perf_clean_hit");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, O_MISS, "perf_dirty");
    for (int i = 0; i < L; i++) busy(1'b1, O_WB, "perf_dirty_wb");
    for (int i = 0; i < L; i++) busy(1'b1, O_REF, "perf_dirty_refill");
    busy(1'b1, O_FILL, "perf_dirty_fill");
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, O_STHIT, "perf_dirty_hit");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, "perf_idle");
    n_cmp++;
    if (hit_count !== 32'd5) begin
      n_err++;
      $display("FAIL hit_count: got %0d expected 5", hit_count);
    end
    n_cmp++;
    if (miss_count !== 32'd2) begin
      n_err++;
      $display("FAIL miss_count: got %0d expected 2", miss_count);
    end
`endif

    rst_b = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
